// File: rtl/invaders_pkg.sv
// Shared types and screen-bound defaults for the invaders player and sprite logic.
// No logic of its own; the helper picks the lowest-index free missile slot.
package invaders_pkg;

    localparam int COL_W        = 12;
    localparam int NUM_MISSILES = 3;
    localparam int MISSILE_EN_W = 8;

    localparam int DEF_DEBOUNCE_CYCLES = 250000;
    localparam int DEF_COL_MIN         = 0;
    localparam int DEF_COL_MAX         = 608;
    localparam int DEF_COL_RESET       = 304;
    localparam int DEF_STEP            = 4;
    localparam int DEF_MISSILE_FRAMES  = 120;
    localparam int DEF_COOLDOWN_FRAMES = 15;

    typedef enum logic {
        READY    = 1'b0,
        COOLDOWN = 1'b1
    } fire_state_t;

    // Counter width that never collapses to zero bits for tiny parameters.
    function automatic int clog2_min1(input int v);
        return (v > 1) ? $clog2(v) : 1;
    endfunction

    function automatic logic [NUM_MISSILES-1:0] lowest_free(input logic [NUM_MISSILES-1:0] busy);
        logic [NUM_MISSILES-1:0] grant;
        grant = '0;
        for (int i = 0; i < NUM_MISSILES; i++) begin
            if (!busy[i] && (grant == '0)) begin
                grant[i] = 1'b1;
            end
        end
        return grant;
    endfunction

endpackage

// File: rtl/button_debounce.sv
// Two-flop synchroniser plus stability counter for one raw pushbutton.
// Latency: level_o follows a clean edge after 2+DEBOUNCE_CYCLES cycles; no backpressure.
module button_debounce
    import invaders_pkg::*;
#(
    parameter int DEBOUNCE_CYCLES = DEF_DEBOUNCE_CYCLES
) (
    input  logic clk,
    input  logic rst,
    input  logic raw_i,
    output logic level_o
);

    localparam int CNT_W = clog2_min1(DEBOUNCE_CYCLES);
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DEBOUNCE_CYCLES - 1);

    logic             sync1_q, sync2_q;
    logic             stable_q, stable_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;

    always_comb begin
        stable_d = stable_q;
        cnt_d    = '0;
        if (sync2_q != stable_q) begin
            if (cnt_q == CNT_LAST) begin
                stable_d = sync2_q;
            end else begin
                cnt_d = cnt_q + CNT_W'(1);
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            sync1_q  <= 1'b0;
            sync2_q  <= 1'b0;
            stable_q <= 1'b0;
            cnt_q    <= '0;
        end else begin
            sync1_q  <= raw_i;
            sync2_q  <= sync1_q;
            stable_q <= stable_d;
            cnt_q    <= cnt_d;
        end
    end

    assign level_o = stable_q;

endmodule

// File: rtl/player_input_ctrl.sv
// Debounced buttons -> per-frame player column, missile slot enables with lifetimes and fire cooldown.
// Latency: column/slots update the cycle after frame_tick or fire event; no backpressure.
module player_input_ctrl
    import invaders_pkg::*;
#(
    parameter int DEBOUNCE_CYCLES = DEF_DEBOUNCE_CYCLES,
    parameter int COL_MIN         = DEF_COL_MIN,
    parameter int COL_MAX         = DEF_COL_MAX,
    parameter int COL_RESET       = DEF_COL_RESET,
    parameter int STEP            = DEF_STEP,
    parameter int MISSILE_FRAMES  = DEF_MISSILE_FRAMES,
    parameter int COOLDOWN_FRAMES = DEF_COOLDOWN_FRAMES
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic                    btn_left_raw,
    input  logic                    btn_right_raw,
    input  logic                    btn_fire_raw,
    input  logic                    vert_sync,
    output logic [COL_W-1:0]        btn_col,
    output logic [MISSILE_EN_W-1:0] btn_missle_en,
    output logic                    frame_tick
);

    localparam int LIFE_W = clog2_min1(MISSILE_FRAMES + 1);
    localparam int CD_W   = clog2_min1(COOLDOWN_FRAMES + 1);

    logic left_lvl, right_lvl, fire_lvl;

    button_debounce #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_db_left (
        .clk     (clk),
        .rst     (rst),
        .raw_i   (btn_left_raw),
        .level_o (left_lvl)
    );

    button_debounce #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_db_right (
        .clk     (clk),
        .rst     (rst),
        .raw_i   (btn_right_raw),
        .level_o (right_lvl)
    );

    button_debounce #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_db_fire (
        .clk     (clk),
        .rst     (rst),
        .raw_i   (btn_fire_raw),
        .level_o (fire_lvl)
    );

    logic                    vs_q;
    logic                    tick_q, tick_d;
    logic [COL_W-1:0]        col_q, col_d;
    logic                    fire_prev_q;
    logic                    fire_evt_q, fire_evt_d;
    fire_state_t             state_q, state_d;
    logic [CD_W-1:0]         cd_q, cd_d;
    logic [NUM_MISSILES-1:0] en_q, en_d;
    logic [LIFE_W-1:0]       life_q [NUM_MISSILES];
    logic [LIFE_W-1:0]       life_d [NUM_MISSILES];
    logic [NUM_MISSILES-1:0] grant;

    logic signed [COL_W:0] col_s, left_s, right_s;

    // End of the active-low sync pulse marks a new frame.
    assign tick_d     = vert_sync & ~vs_q;
    assign fire_evt_d = fire_lvl & ~fire_prev_q;

    // One extra bit of signed headroom keeps left moves from wrapping below zero.
    always_comb begin
        col_s   = $signed({1'b0, col_q});
        left_s  = col_s - $signed((COL_W+1)'(STEP));
        right_s = col_s + $signed((COL_W+1)'(STEP));
        col_d   = col_q;
        if (tick_q) begin
            if (left_lvl && !right_lvl) begin
                col_d = (left_s < $signed((COL_W+1)'(COL_MIN))) ? COL_W'(COL_MIN)
                                                               : left_s[COL_W-1:0];
            end else if (right_lvl && !left_lvl) begin
                col_d = (right_s > $signed((COL_W+1)'(COL_MAX))) ? COL_W'(COL_MAX)
                                                                : right_s[COL_W-1:0];
            end
        end
    end

    // Allocation looks at en_q, so a slot expiring on this tick is still seen as busy.
    always_comb begin
        state_d = state_q;
        cd_d    = cd_q;
        en_d    = en_q;
        life_d  = life_q;
        grant   = lowest_free(en_q);

        if (tick_q) begin
            for (int i = 0; i < NUM_MISSILES; i++) begin
                if (en_q[i]) begin
                    life_d[i] = life_q[i] - LIFE_W'(1);
                    if (life_q[i] == LIFE_W'(1)) begin
                        en_d[i] = 1'b0;
                    end
                end
            end
        end

        case (state_q)
            READY: begin
                if (fire_evt_q && (grant != '0)) begin
                    for (int i = 0; i < NUM_MISSILES; i++) begin
                        if (grant[i]) begin
                            en_d[i]   = 1'b1;
                            life_d[i] = LIFE_W'(MISSILE_FRAMES);
                        end
                    end
                    cd_d    = CD_W'(COOLDOWN_FRAMES);
                    state_d = (COOLDOWN_FRAMES == 0) ? READY : COOLDOWN;
                end
            end
            COOLDOWN: begin
                if (tick_q) begin
                    cd_d = (cd_q == '0) ? '0 : cd_q - CD_W'(1);
                    if (cd_q <= CD_W'(1)) begin
                        state_d = READY;
                    end
                end
            end
            default: state_d = READY;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            vs_q        <= 1'b1;
            tick_q      <= 1'b0;
            col_q       <= COL_W'(COL_RESET);
            fire_prev_q <= 1'b0;
            fire_evt_q  <= 1'b0;
            state_q     <= READY;
            cd_q        <= '0;
            en_q        <= '0;
            for (int i = 0; i < NUM_MISSILES; i++) begin
                life_q[i] <= '0;
            end
        end else begin
            vs_q        <= vert_sync;
            tick_q      <= tick_d;
            col_q       <= col_d;
            fire_prev_q <= fire_lvl;
            fire_evt_q  <= fire_evt_d;
            state_q     <= state_d;
            cd_q        <= cd_d;
            en_q        <= en_d;
            for (int i = 0; i < NUM_MISSILES; i++) begin
                life_q[i] <= life_d[i];
            end
        end
    end

    assign btn_col       = col_q;
    assign btn_missle_en = {{(MISSILE_EN_W-NUM_MISSILES){1'b0}}, en_q};
    assign frame_tick    = tick_q;

endmodule

// File: tb/tb_player_input_ctrl.sv
// Directed bench for player_input_ctrl with short debounce and lifetimes.
module tb_player_input_ctrl;

    logic        clk;
    logic        rst;
    logic        btn_left_raw;
    logic        btn_right_raw;
    logic        btn_fire_raw;
    logic        vert_sync;
    logic [11:0] btn_col;
    logic [7:0]  btn_missle_en;
    logic        frame_tick;

    int tests_run    = 0;
    int tests_failed = 0;

    player_input_ctrl #(
        .DEBOUNCE_CYCLES (4),
        .MISSILE_FRAMES  (3),
        .COOLDOWN_FRAMES (2),
        .STEP            (4)
    ) dut (
        .clk           (clk),
        .rst           (rst),
        .btn_left_raw  (btn_left_raw),
        .btn_right_raw (btn_right_raw),
        .btn_fire_raw  (btn_fire_raw),
        .vert_sync     (vert_sync),
        .btn_col       (btn_col),
        .btn_missle_en (btn_missle_en),
        .frame_tick    (frame_tick)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    task automatic check(input string tag, input int obs, input int exp);
        tests_run++;
        if (obs != exp) begin
            tests_failed++;
            $display("FAIL %s: got %0d, expected %0d", tag, obs, exp);
        end
    endtask

    // Advance n clock edges; land 1 ns after the last edge.
    task automatic cyc(input int n);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    // One frame: tick registered 3 edges in, column/slots updated on the 4th.
    task automatic frame();
        vert_sync = 1'b0;
        cyc(2);
        vert_sync = 1'b1;
        cyc(2);
    endtask

    // Fire press long enough to be accepted, then released and settled; no ticks inside.
    task automatic fire_pulse();
        btn_fire_raw = 1'b1;
        cyc(8);
        btn_fire_raw = 1'b0;
        cyc(8);
    endtask

    // Fire event and frame_tick land in the same cycle.
    task automatic fire_on_tick();
        btn_fire_raw = 1'b1;
        vert_sync    = 1'b0;
        cyc(6);
        vert_sync    = 1'b1;
        cyc(2);
        btn_fire_raw = 1'b0;
        cyc(8);
    endtask

    initial begin
        #200000;
        $display("FAIL timeout: simulation did not finish, got running, expected finished");
        $fatal(1, "timeout");
    end

    initial begin
        int exp_left [5];
        int ticks;
        exp_left = '{4, 0, 0, 0, 0};

        rst           = 1'b0;
        btn_left_raw  = 1'b0;
        btn_right_raw = 1'b0;
        btn_fire_raw  = 1'b0;
        vert_sync     = 1'b1;
        #2 rst = 1'b1;
        #1;
        check("rst_col", int'(btn_col), 304);
        check("rst_en", int'(btn_missle_en), 0);
        check("rst_tick", int'(frame_tick), 0);
        cyc(2);
        rst = 1'b0;
        cyc(1);
        check("no_tick_after_rst", int'(frame_tick), 0);

        // Short glitch never reaches the stable level.
        btn_fire_raw = 1'b1;
        cyc(3);
        btn_fire_raw = 1'b0;
        cyc(10);
        check("glitch_no_fire", int'(btn_missle_en), 0);

        // Clean press: slot 0 appears exactly 8 edges after the raw edge.
        btn_fire_raw = 1'b1;
        cyc(7);
        check("fire_lat_early", int'(btn_missle_en), 0);
        cyc(1);
        check("fire_lat_slot0", int'(btn_missle_en), 1);
        cyc(2);
        btn_fire_raw = 1'b0;
        cyc(8);

        fire_pulse();
        check("cooldown_ignore", int'(btn_missle_en), 1);
        frame();
        frame();
        check("slot0_alive_t2", int'(btn_missle_en), 1);

        // Slot 0 expires on this tick; launch must take slot 1 instead.
        fire_on_tick();
        check("expiry_no_reuse", int'(btn_missle_en), 2);
        frame();
        check("launch_tick_no_dec", int'(btn_missle_en), 2);
        fire_pulse();
        check("cd_not_dec_on_launch", int'(btn_missle_en), 2);
        frame();
        fire_pulse();
        check("reuse_slot0", int'(btn_missle_en), 3);
        frame();
        check("slot1_expired", int'(btn_missle_en), 1);
        frame();
        frame();
        check("slot0_expired", int'(btn_missle_en), 0);
        check("col_idle", int'(btn_col), 304);

        // Movement with saturation at both ends.
        btn_left_raw = 1'b1;
        cyc(8);
        check("no_move_between_ticks", int'(btn_col), 304);
        repeat (74) frame();
        check("left_to_8", int'(btn_col), 8);
        for (int i = 0; i < 5; i++) begin
            frame();
            check($sformatf("left_sat_%0d", i), int'(btn_col), exp_left[i]);
        end
        btn_left_raw  = 1'b0;
        btn_right_raw = 1'b1;
        cyc(8);
        repeat (151) frame();
        check("right_to_604", int'(btn_col), 604);
        btn_left_raw = 1'b1;
        cyc(8);
        frame();
        check("both_hold", int'(btn_col), 604);
        btn_left_raw = 1'b0;
        cyc(8);
        frame();
        check("right_sat_608", int'(btn_col), 608);
        frame();
        check("right_stay_608", int'(btn_col), 608);
        btn_right_raw = 1'b0;
        cyc(8);

        // Single pulse one cycle after the vert_sync rising edge.
        vert_sync = 1'b0;
        cyc(2);
        check("tick_before_edge", int'(frame_tick), 0);
        vert_sync = 1'b1;
        cyc(1);
        check("tick_pulse", int'(frame_tick), 1);
        cyc(1);
        check("tick_one_cycle", int'(frame_tick), 0);

        ticks = 0;
        vert_sync = 1'b0;
        for (int i = 0; i < 12; i++) begin
            cyc(1);
            if (frame_tick) ticks++;
        end
        check("no_tick_sync_low", ticks, 0);
        vert_sync = 1'b1;
        cyc(3);

        // Async reset mid-frame with a live missile and moved player.
        fire_pulse();
        check("pre_reset_en", int'(btn_missle_en), 1);
        vert_sync = 1'b0;
        @(posedge clk);
        #3 rst = 1'b1;
        #1;
        check("async_rst_col", int'(btn_col), 304);
        check("async_rst_en", int'(btn_missle_en), 0);
        check("async_rst_tick", int'(frame_tick), 0);
        cyc(2);
        rst = 1'b0;
        vert_sync = 1'b1;
        cyc(3);
        check("post_rst_col", int'(btn_col), 304);
        check("post_rst_en", int'(btn_missle_en), 0);

        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

endmodule
